// File: rtl/wisc_pkg.sv
// wisc_pkg: shared widths, fetch queue entry type and prefetch state encoding
package wisc_pkg;
    localparam int WORD_W = 16;
    localparam int PC_W   = 16;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {ST_RUN, ST_HALTED} state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: in-order queue with occupancy count, flush and same-cycle push/pop
module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rp, wp;
    logic          do_push, do_pop;

    assign do_pop  = pop && count != '0;
    assign do_push = push && (count != FULL || do_pop);
    assign dout    = mem[rp];

    // storage, pointers and count; flush empties the queue without touching storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp    <= '0;
            wp    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rp    <= '0;
            wp    <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= din;
                wp      <= wp + 1'b1;
            end
            if (do_pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: sequential instruction prefetch with in-order queue, redirect flush and halt
module if_prefetch
    import wisc_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [PC_W-1:0]   mem_addr,
    input  logic              mem_rvalid,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              instr_valid,
    output logic [WORD_W-1:0] instr,
    output logic [PC_W-1:0]   instr_pc,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              halt,
    output logic              halted
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

    state_t          state, state_n;
    logic [PC_W-1:0] fetch_pc;
    logic [CW-1:0]   occ, live, drop;
    logic [CW:0]     occ_sum, out_sum;
    logic [PC_W-1:0] tag [DEPTH];
    logic [AW-1:0]   tag_wp, tag_rp;
    logic            issue, flush;
    logic            rsp_drop, rsp_live, rsp_any;
    logic            push, pop;
    fetch_entry_t    entry_in, head;

    // reservation: queued plus live must fit the queue, and all outstanding must fit the tag shadow
    assign occ_sum  = {1'b0, occ} + {1'b0, live};
    assign out_sum  = {1'b0, live} + {1'b0, drop};

    // stale responses are always older than kept ones, so drop is served first
    assign rsp_drop = mem_rvalid && drop != '0;
    assign rsp_live = mem_rvalid && drop == '0 && live != '0;
    assign rsp_any  = rsp_drop || rsp_live;

    assign push     = rsp_live && !flush;
    assign pop      = instr_valid && instr_ready && !flush;
    assign entry_in = '{pc: tag[tag_rp], instr: mem_rdata};

    assign mem_req     = issue;
    assign mem_addr    = fetch_pc;
    assign halted      = state == ST_HALTED;
    assign instr_valid = occ != '0;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_n;
    end

    // next state, flush and issue decision; halt dominates redirect
    always_comb begin
        state_n = state;
        flush   = 1'b0;
        issue   = 1'b0;
        if (state == ST_RUN) begin
            flush = redirect || halt;
            issue = rst_n && !flush && occ_sum < LIMIT && out_sum < LIMIT;
            if (halt) state_n = ST_HALTED;
        end
    end

    // fetch pointer and outstanding-request counters; a flush converts live into drop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            live     <= '0;
            drop     <= '0;
        end else if (flush) begin
            live <= '0;
            drop <= drop + live - CW'(rsp_any);
            if (!halt) fetch_pc <= redirect_pc;
        end else begin
            live <= live + CW'(issue) - CW'(rsp_live);
            drop <= drop - CW'(rsp_drop);
            if (issue) fetch_pc <= fetch_pc + 1'b1;
        end
    end

    // tag shadow pointers: write on issue, retire on every accounted response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_wp <= '0;
            tag_rp <= '0;
        end else begin
            if (issue)   tag_wp <= tag_wp + 1'b1;
            if (rsp_any) tag_rp <= tag_rp + 1'b1;
        end
    end

    // tag shadow storage holds the PC of each outstanding request in issue order
    always_ff @(posedge clk) begin
        if (issue) tag[tag_wp] <= fetch_pc;
    end

    sync_fifo #(
        .W     ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .din   (entry_in),
        .pop   (pop),
        .dout  (head),
        .count (occ)
    );
endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: directed self-checking bench for if_prefetch with a variable-latency memory model
module tb_if_prefetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready = 1'b1;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        halted;

    int passed = 0;
    int fails  = 0;
    int total  = 0;
    int lat    = 1;

    logic [7:0]  sv = '0;
    logic [15:0] sa [8];

    if_prefetch #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // in-order memory: a request accepted at an edge answers lat cycles later with addr^A5A5
    always @(posedge clk) begin
        sv <= {sv[6:0], mem_req};
        for (int i = 7; i > 0; i--) sa[i] <= sa[i-1];
        sa[0] <= mem_addr;
    end
    assign mem_rvalid = sv[lat-1];
    assign mem_rdata  = sa[lat-1] ^ 16'hA5A5;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        halt     = 1'b0;
        redirect = 1'b0;
        repeat (10) step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!instr_valid && n < 20) begin
            step();
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        logic [15:0] exp_pc [3];

        // reset values while held in reset
        repeat (3) step();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_halted", halted, 0);

        // streaming with 1-cycle memory
        lat = 1;
        do_reset();
        chk("t1_first_req", mem_req, 1);
        chk("t1_first_addr", mem_addr, 16'h0000);
        chk("t1_c1_valid", instr_valid, 0);
        step();
        chk("t1_c2_valid", instr_valid, 0);
        chk("t1_c2_addr", mem_addr, 16'h0001);
        step();
        for (int k = 0; k < 6; k++) begin
            chk("t1_valid", instr_valid, 1);
            chk("t1_pc", instr_pc, k);
            chk("t1_instr", instr, k ^ 16'hA5A5);
            step();
        end

        // backpressure fills the queue with exactly four requests
        instr_ready = 1'b0;
        do_reset();
        n = 0;
        for (int k = 0; k < 10; k++) begin
            if (mem_req) n++;
            step();
        end
        chk("t2_req_count", n, 4);
        chk("t2_req_stopped", mem_req, 0);
        chk("t2_head_valid", instr_valid, 1);
        chk("t2_head_pc", instr_pc, 16'h0000);
        chk("t2_head_instr", instr, 16'hA5A5);
        instr_ready = 1'b1;
        #1;
        chk("t2_full_no_req", mem_req, 0);
        step();
        chk("t2_resume_req", mem_req, 1);
        chk("t2_resume_addr", mem_addr, 16'h0004);
        chk("t2_next_pc", instr_pc, 16'h0001);

        // 3-cycle memory, redirect with three requests outstanding
        lat = 3;
        do_reset();
        step();
        step();
        step();
        chk("t3_c4_req", mem_req, 1);
        chk("t3_c4_addr", mem_addr, 16'h0003);
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        #1;
        chk("t3_redir_no_req", mem_req, 0);
        step();
        redirect = 1'b0;
        #1;
        chk("t3_after_valid", instr_valid, 0);
        chk("t3_after_req", mem_req, 1);
        chk("t3_after_addr", mem_addr, 16'h0040);
        wait_valid(n);
        chk("t3_latency", n, 4);
        chk("t3_pc0", instr_pc, 16'h0040);
        chk("t3_instr0", instr, 16'h0040 ^ 16'hA5A5);
        step();
        chk("t3_valid1", instr_valid, 1);
        chk("t3_pc1", instr_pc, 16'h0041);

        // redirect near the top of the address space wraps
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        step();
        redirect = 1'b0;
        #1;
        chk("t4_flushed", instr_valid, 0);
        exp_pc[0] = 16'hFFFE;
        exp_pc[1] = 16'hFFFF;
        exp_pc[2] = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            wait_valid(n);
            chk("t4_valid", instr_valid, 1);
            chk("t4_pc", instr_pc, exp_pc[k]);
            chk("t4_instr", instr, exp_pc[k] ^ 16'hA5A5);
            step();
        end

        // halt with two requests outstanding; a later redirect is ignored
        do_reset();
        step();
        step();
        halt = 1'b1;
        #1;
        chk("t5_halt_no_req", mem_req, 0);
        step();
        halt = 1'b0;
        #1;
        chk("t5_halted", halted, 1);
        chk("t5_req", mem_req, 0);
        chk("t5_valid", instr_valid, 0);
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        step();
        redirect = 1'b0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (mem_req || instr_valid) bad++;
            step();
        end
        chk("t5_quiet", bad, 0);
        chk("t5_still_halted", halted, 1);
        chk("t5_addr_kept", mem_addr, 16'h0002);

        // reset pulse mid-stream with responses pending
        do_reset();
        repeat (5) step();
        chk("t6_streaming", instr_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_req", mem_req, 0);
        chk("t6_rst_addr", mem_addr, 16'h0000);
        chk("t6_rst_valid", instr_valid, 0);
        chk("t6_rst_instr", instr, 0);
        chk("t6_rst_pc", instr_pc, 0);
        chk("t6_rst_halted", halted, 0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("t6_restart_req", mem_req, 1);
        chk("t6_restart_addr", mem_addr, 16'h0000);
        wait_valid(n);
        chk("t6_latency", n, 4);
        chk("t6_pc0", instr_pc, 16'h0000);
        chk("t6_instr0", instr, 16'hA5A5);
        step();
        chk("t6_pc1", instr_pc, 16'h0001);
        chk("t6_instr1", instr, 16'hA5A4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
